// File: rtl/uart_reg_bridge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_reg_bridge: UART byte frames ('W' a d / 'R' a) to reg bus    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module uart_reg_bridge #(
  parameter int TIMEOUT_CLKS = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       frame_err
);

  localparam logic [7:0]  OP_WRITE     = 8'h57;
  localparam logic [7:0]  OP_READ      = 8'h52;
  localparam logic [7:0]  RESP_ERR     = 8'h45;
  localparam logic [7:0]  RESP_OK      = 8'h4B;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    BUS_WR   = 3'd3,
    BUS_RD   = 3'd4,
    RD_WAIT  = 3'd5,
    SEND     = 3'd6,
    WAIT_TX  = 3'd7
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  rst_sync;
  logic        rst_n;
  logic        is_write;
  logic [3:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  tx_q;
  logic [15:0] idle_cnt;
  logic        in_frame;
  logic        timeout_hit;
  logic        op_valid;

  // Assertion propagates immediately; release is delayed two clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign in_frame    = (state == GET_ADDR) || (state == GET_DATA);
  assign timeout_hit = in_frame && !rx_valid && (idle_cnt == TIMEOUT_LAST);
  assign op_valid    = (rx_data == OP_WRITE) || (rx_data == OP_READ);

  always_comb begin
    state_nxt = state;
    tx_send   = 1'b0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (op_valid) begin
            state_nxt = GET_ADDR;
          end else begin
            state_nxt = SEND;
            frame_err = 1'b1;
          end
        end
      end
      GET_ADDR: begin
        if (rx_valid)         state_nxt = is_write ? GET_DATA : BUS_RD;
        else if (timeout_hit) begin
          state_nxt = IDLE;
          frame_err = 1'b1;
        end
      end
      GET_DATA: begin
        if (rx_valid)         state_nxt = BUS_WR;
        else if (timeout_hit) begin
          state_nxt = IDLE;
          frame_err = 1'b1;
        end
      end
      BUS_WR: begin
        reg_we    = 1'b1;
        frame_err = rx_valid;
        state_nxt = SEND;
      end
      BUS_RD: begin
        reg_re    = 1'b1;
        frame_err = rx_valid;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        frame_err = rx_valid;
        state_nxt = SEND;
      end
      SEND: begin
        frame_err = rx_valid;
        if (!tx_busy) begin
          tx_send   = 1'b1;
          state_nxt = WAIT_TX;
        end
      end
      WAIT_TX: begin
        frame_err = rx_valid;
        if (tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      is_write <= 1'b0;
      addr_q   <= 4'h0;
      wdata_q  <= 8'h00;
      tx_q     <= 8'h00;
      idle_cnt <= 16'h0000;
    end else begin
      state <= state_nxt;
      // Counter is zero on entry to an address/data wait and after every byte.
      if (in_frame && !rx_valid) idle_cnt <= idle_cnt + 16'h0001;
      else                       idle_cnt <= 16'h0000;
      case (state)
        IDLE: begin
          if (rx_valid && op_valid)  is_write <= (rx_data == OP_WRITE);
          if (rx_valid && !op_valid) tx_q     <= RESP_ERR;
        end
        GET_ADDR: if (rx_valid) addr_q  <= rx_data[3:0];
        GET_DATA: if (rx_valid) wdata_q <= rx_data;
        BUS_WR:   tx_q <= RESP_OK;
        RD_WAIT:  tx_q <= reg_rdata;
        default:  ;
      endcase
    end
  end

  assign tx_data   = tx_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;

endmodule
`default_nettype wire
